dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 152 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller between the
// CPU MEM stage and a line-wide backing memory with an enable/ack handshake.
module dcache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int WOFF_W  = 3,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic                      rd_i,
  input  logic                      wr_i,
  input  logic [31:0]               wdata_i,
  output logic [31:0]               rdata_o,
  output logic                      stall_o,
  output logic                      mem_enable_o,
  output logic                      mem_write_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [(32<<WOFF_W)-1:0]   mem_wdata_o,
  input  logic [(32<<WOFF_W)-1:0]   mem_rdata_i,
  input  logic                      mem_ack_i,
  output logic [31:0]               access_cnt_o,
  output logic [31:0]               miss_cnt_o
);

  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int LINE_W    = 32 << WOFF_W;
  localparam int LOW_W     = WOFF_W + 2;
  localparam int TAG_W     = ADDR_W - INDEX_W - WOFF_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [NUM_LINES-1:0]    valid_r, dirty_r;
  logic [TAG_W-1:0]        tag_mem_r  [NUM_LINES];
  logic [LINE_W-1:0]       data_mem_r [NUM_LINES];
  logic [31:0]             access_cnt_r, miss_cnt_r;

  logic [WOFF_W-1:0]       offset_s;
  logic [INDEX_W-1:0]      index_s;
  logic [TAG_W-1:0]        tag_s;
  logic [LINE_W-1:0]       line_s;
  logic                    req_s, hit_s;
  logic                    do_store_s, do_fill_s, count_access_s, count_miss_s;
  logic                    addr_lsb_unused_s;

  assign offset_s          = addr_i[WOFF_W+1:2];
  assign index_s           = addr_i[INDEX_W+WOFF_W+1:WOFF_W+2];
  assign tag_s             = addr_i[ADDR_W-1:ADDR_W-TAG_W];
  assign addr_lsb_unused_s = &addr_i[1:0];
  assign req_s             = rd_i | wr_i;
  assign line_s            = data_mem_r[index_s];
  assign hit_s             = req_s & valid_r[index_s] & (tag_mem_r[index_s] == tag_s);
  assign access_cnt_o      = access_cnt_r;
  assign miss_cnt_o        = miss_cnt_r;

  // Next-state, stall, CPU read data and memory request decode.
  always_comb begin
    state_s        = state_r;
    stall_o        = 1'b0;
    rdata_o        = 32'd0;
    mem_enable_o   = 1'b0;
    mem_write_o    = 1'b0;
    mem_addr_o     = {ADDR_W{1'b0}};
    mem_wdata_o    = {LINE_W{1'b0}};
    do_store_s     = 1'b0;
    do_fill_s      = 1'b0;
    count_access_s = 1'b0;
    count_miss_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            rdata_o        = line_s[{offset_s, 5'b00000} +: 32];
            do_store_s     = wr_i;
            count_access_s = 1'b1;
          end else begin
            stall_o      = 1'b1;
            count_miss_s = 1'b1;
            if (valid_r[index_s] && dirty_r[index_s]) begin
              state_s = ST_WRITEBACK;
            end else begin
              state_s = ST_ALLOCATE;
            end
          end
        end else begin
          stall_o = 1'b0;
        end
      end
      ST_WRITEBACK: begin
        stall_o      = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_mem_r[index_s], index_s, {LOW_W{1'b0}}};
        mem_wdata_o  = line_s;
        if (mem_ack_i) begin
          state_s = ST_ALLOCATE;
        end else begin
          state_s = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        stall_o      = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag_s, index_s, {LOW_W{1'b0}}};
        if (mem_ack_i) begin
          do_fill_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_ALLOCATE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, line status bits and access/miss counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= ST_IDLE;
      valid_r      <= {NUM_LINES{1'b0}};
      dirty_r      <= {NUM_LINES{1'b0}};
      access_cnt_r <= 32'd0;
      miss_cnt_r   <= 32'd0;
    end else begin
      state_r <= state_s;
      if (do_store_s) dirty_r[index_s] <= 1'b1;
      if (do_fill_s) begin
        valid_r[index_s] <= 1'b1;
        dirty_r[index_s] <= 1'b0;
      end
      if (count_access_s) access_cnt_r <= access_cnt_r + 32'd1;
      if (count_miss_s)   miss_cnt_r   <= miss_cnt_r + 32'd1;
    end
  end

  // Tag and data arrays; contents are qualified by valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_store_s) data_mem_r[index_s][{offset_s, 5'b00000} +: 32] <= wdata_i;
    if (do_fill_s) begin
      data_mem_r[index_s] <= mem_rdata_i;
      tag_mem_r[index_s]  <= tag_s;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: refill, store hits, dirty
// eviction, early/stray acks, dual rd/wr and reset mid-transfer.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i, wdata_i, rdata_o, mem_addr_o, access_cnt_o, miss_cnt_o;
  logic         rd_i, wr_i, stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [255:0] mem_wdata_o, mem_rdata_i;

  int errors = 0;
  int checks = 0;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .rd_i(rd_i), .wr_i(wr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .access_cnt_o(access_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] w0);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    l[31:0] = w0;
    return l;
  endfunction

  initial begin
    rst_i = 1'b0; addr_i = 32'd0; rd_i = 1'b0; wr_i = 1'b0; wdata_i = 32'd0;
    mem_ack_i = 1'b0; mem_rdata_i = 256'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
    check_eq("rst_enable", {31'd0, mem_enable_o}, 32'd0);
    check_eq("rst_write", {31'd0, mem_write_o}, 32'd0);
    check_eq("rst_addr", mem_addr_o, 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_access", access_cnt_o, 32'd0);
    check_eq("rst_miss", miss_cnt_o, 32'd0);
    rst_i = 1'b1;
    tick();

    // Clean miss on 0x40, memory answers after 10 cycles
    addr_i = 32'h0000_0040; rd_i = 1'b1; #1;
    check_eq("miss_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check_eq("alloc_enable", {31'd0, mem_enable_o}, 32'd1);
    check_eq("alloc_write", {31'd0, mem_write_o}, 32'd0);
    check_eq("alloc_addr", mem_addr_o, 32'h0000_0040);
    check_eq("miss_cnt1", miss_cnt_o, 32'd1);
    repeat (8) tick();
    check_eq("alloc_wait_stall", {31'd0, stall_o}, 32'd1);
    mem_rdata_i = mk_line(32'h1000_0000, 32'hDEAD_BEEF); mem_ack_i = 1'b1; #1;
    check_eq("ack_cycle_stall", {31'd0, stall_o}, 32'd1);
    tick();
    mem_ack_i = 1'b0; #1;
    check_eq("refill_rdata", rdata_o, 32'hDEAD_BEEF);
    check_eq("refill_stall", {31'd0, stall_o}, 32'd0);
    check_eq("refill_enable", {31'd0, mem_enable_o}, 32'd0);
    tick();
    check_eq("access_cnt1", access_cnt_o, 32'd1);
    check_eq("miss_cnt1b", miss_cnt_o, 32'd1);

    // Store hit then load hits in the same line
    rd_i = 1'b0; wr_i = 1'b1; addr_i = 32'h0000_0044; wdata_i = 32'h1234_5678; #1;
    check_eq("sw_stall", {31'd0, stall_o}, 32'd0);
    check_eq("sw_enable", {31'd0, mem_enable_o}, 32'd0);
    tick();
    wr_i = 1'b0; rd_i = 1'b1; #1;
    check_eq("lw44_rdata", rdata_o, 32'h1234_5678);
    check_eq("lw44_stall", {31'd0, stall_o}, 32'd0);
    check_eq("lw44_enable", {31'd0, mem_enable_o}, 32'd0);
    tick();
    addr_i = 32'h0000_0048; #1;
    check_eq("lw48_rdata", rdata_o, 32'h1000_0002);
    tick();
    check_eq("access_cnt4", access_cnt_o, 32'd4);

    // Conflict miss on dirty line: write-back of 0x40 then allocate 0x440
    addr_i = 32'h0000_0440; #1;
    check_eq("conf_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check_eq("wb_enable", {31'd0, mem_enable_o}, 32'd1);
    check_eq("wb_write", {31'd0, mem_write_o}, 32'd1);
    check_eq("wb_addr", mem_addr_o, 32'h0000_0040);
    check_eq("wb_word1", mem_wdata_o[63:32], 32'h1234_5678);
    check_eq("wb_word0", mem_wdata_o[31:0], 32'hDEAD_BEEF);
    check_eq("miss_cnt2", miss_cnt_o, 32'd2);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check_eq("alloc2_enable", {31'd0, mem_enable_o}, 32'd1);
    check_eq("alloc2_write", {31'd0, mem_write_o}, 32'd0);
    check_eq("alloc2_addr", mem_addr_o, 32'h0000_0440);
    tick(); tick();
    mem_rdata_i = mk_line(32'hA000_0000, 32'hA000_0000); mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0; #1;
    check_eq("lw440_rdata", rdata_o, 32'hA000_0000);
    check_eq("lw440_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check_eq("access_cnt5", access_cnt_o, 32'd5);
    check_eq("miss_cnt2b", miss_cnt_o, 32'd2);

    // Ack in the very first allocate cycle
    addr_i = 32'h0000_0080; #1;
    tick();
    mem_rdata_i = mk_line(32'h2000_0000, 32'h0BAD_F00D); mem_ack_i = 1'b1; #1;
    check_eq("early_enable", {31'd0, mem_enable_o}, 32'd1);
    tick();
    mem_ack_i = 1'b0; #1;
    check_eq("early_rdata", rdata_o, 32'h0BAD_F00D);
    check_eq("early_stall", {31'd0, stall_o}, 32'd0);
    tick();

    // Stray ack while idle
    rd_i = 1'b0; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0; #1;
    check_eq("stray_enable", {31'd0, mem_enable_o}, 32'd0);
    check_eq("stray_stall", {31'd0, stall_o}, 32'd0);
    check_eq("stray_miss", miss_cnt_o, 32'd3);
    check_eq("stray_access", access_cnt_o, 32'd6);
    rd_i = 1'b1; #1;
    check_eq("stray_rehit", rdata_o, 32'h0BAD_F00D);
    tick();

    // rd and wr together act as a store
    wr_i = 1'b1; wdata_i = 32'h55AA_55AA; #1;
    check_eq("rdwr_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check_eq("access_cnt8", access_cnt_o, 32'd8);
    wr_i = 1'b0; #1;
    check_eq("rdwr_readback", rdata_o, 32'h55AA_55AA);
    tick();
    addr_i = 32'h0000_0480; #1;
    tick();
    check_eq("rdwr_wb_write", {31'd0, mem_write_o}, 32'd1);
    check_eq("rdwr_wb_addr", mem_addr_o, 32'h0000_0080);
    check_eq("rdwr_wb_word0", mem_wdata_o[31:0], 32'h55AA_55AA);
    check_eq("miss_cnt4", miss_cnt_o, 32'd4);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check_eq("pre_rst_addr", mem_addr_o, 32'h0000_0480);

    // Reset in the middle of an allocate
    #1 rst_i = 1'b0; #1;
    check_eq("midrst_enable", {31'd0, mem_enable_o}, 32'd0);
    check_eq("midrst_access", access_cnt_o, 32'd0);
    check_eq("midrst_miss", miss_cnt_o, 32'd0);
    rd_i = 1'b0;
    tick();
    rst_i = 1'b1; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check_eq("postrst_enable", {31'd0, mem_enable_o}, 32'd0);
    check_eq("postrst_miss", miss_cnt_o, 32'd0);
    rd_i = 1'b1; #1;
    check_eq("postrst_remiss", {31'd0, stall_o}, 32'd1);
    tick();
    check_eq("postrst_miss1", miss_cnt_o, 32'd1);
    check_eq("postrst_alloc_write", {31'd0, mem_write_o}, 32'd0);
    check_eq("postrst_alloc_addr", mem_addr_o, 32'h0000_0480);
    mem_rdata_i = mk_line(32'h3000_0000, 32'h3000_0000); mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0; #1;
    check_eq("postrst_rdata", rdata_o, 32'h3000_0000);
    tick();
    check_eq("postrst_access1", access_cnt_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
